// File: rtl/serial_addr_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default operand width.
// No logic, no latency.
package serial_addr_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/serial_addr_full_addr.sv
// One-bit full-adder cell used as the serial adder's only arithmetic element.
// Purely combinational, zero latency, no flow control.
module full_addr (
   input  logic in1,
   input  logic in2,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic half_sum;

   assign half_sum = in1 ^ in2;
   assign sum      = half_sum ^ cin;
   assign cout     = (in1 & in2) | (cin & half_sum);

endmodule

// File: rtl/serial_addr.sv
// Bit-serial adder, LSB first through one full-adder cell; optional subtract via SERIAL_ADDR_SUB_EN.
// Result and done pulse WIDTH edges after the accepted start; start is ignored while busy.
module serial_addr
   import serial_addr_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDR_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int                CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;

   logic             fa_sum, fa_cout;
   logic [WIDTH-1:0] opb_load;
   logic             carry_load;

   // Subtraction is a + ~b + 1, so only the B operand and initial carry change.
`ifdef SERIAL_ADDR_SUB_EN
   assign opb_load   = sub ? ~b : b;
   assign carry_load = sub ? 1'b1 : cin;
`else
   assign opb_load   = b;
   assign carry_load = cin;
`endif

   full_addr u_fa (
      .in1  (opa_q[0]),
      .in2  (opb_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               opa_d   = a;
               opb_d   = opb_load;
               carry_d = carry_load;
               res_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            opa_d   = opa_q >> 1;
            opb_d   = opb_q >> 1;
            carry_d = fa_cout;
            res_d   = {fa_sum, res_q[WIDTH-1:1]};
            // Counter parks at LAST so it never wraps; the visible result updates only here.
            if (cnt_q == LAST) begin
               sum_d   = res_d;
               cout_d  = fa_cout;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule
